// File: rtl/link_rx.sv
// link_rx: 8N1 UART receiver with a small receive FIFO behind a memory-mapped data/status register pair
module link_rx #(
  parameter int          CLKS_PER_BIT = 36,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] DATA_ADDR    = 16'hff08,
  parameter logic [15:0] STAT_ADDR    = 16'hff09
) (
  input  logic        clock4,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  indata,
  output logic [7:0]  outdata,
  input  logic        load,
  input  logic        store,
  input  logic        UART_RX,
  output logic        irq
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic rx_m, rx_s, armed, tick, half, push, ferr_set;
  logic [CW-1:0] cnt;
  logic [2:0] bidx;
  logic [7:0] shreg;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [2:0] count;
  logic overflow, frame_err, full, empty, rd_data, pop, accept, st_stat;
  logic [7:0] status;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign tick = cnt == CW'(CLKS_PER_BIT - 1);
  assign half = cnt == CW'(CLKS_PER_BIT / 2 - 1);
  always_ff @(posedge clock4)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (armed && !rx_s) state_n = START;
      START: if (half) state_n = rx_s ? IDLE : DATA;
      DATA:  if (tick && bidx == 3'd7) state_n = STOP;
      STOP:  if (tick) state_n = IDLE;
    endcase
  end
  always_comb begin
    push     = state == STOP && tick && rx_s;
    ferr_set = state == STOP && tick && !rx_s;
  end
  always_ff @(posedge clock4)
    if (reset) begin
      rx_m  <= 1'b1;
      rx_s  <= 1'b1;
      armed <= 1'b0;
      cnt   <= '0;
      bidx  <= '0;
      shreg <= '0;
    end else begin
      rx_m  <= UART_RX;
      rx_s  <= rx_m;
      armed <= (state == STOP && tick) ? 1'b0 : (state == IDLE && rx_s) ? 1'b1 : armed;
      cnt   <= (state == IDLE || state_n != state || tick) ? '0 : cnt + 1'b1;
      if (state == DATA && tick) begin
        bidx  <= bidx + 1'b1;
        shreg <= {rx_s, shreg[7:1]};
      end
    end
  // a pop frees the slot the coincident push needs, so a full FIFO still accepts it
  always_comb begin
    full    = count == 3'(FIFO_DEPTH);
    empty   = count == 3'd0;
    rd_data = load && !store && address == DATA_ADDR;
    pop     = rd_data && !empty;
    accept  = push && (!full || pop);
    st_stat = store && address == STAT_ADDR;
    status  = {!empty, full, overflow, frame_err, 1'b0, count};
  end
  always_ff @(posedge clock4)
    if (accept) mem[wp] <= shreg;
  always_ff @(posedge clock4)
    if (reset) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      irq       <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      outdata   <= 8'h00;
    end else begin
      if (accept) wp <= nxt(wp);
      if (pop) rp <= nxt(rp);
      count     <= count + 3'(accept) - 3'(pop);
      irq       <= accept;
      overflow  <= (push && full && !pop) || (overflow && !(st_stat && indata[5]));
      frame_err <= ferr_set || (frame_err && !(st_stat && indata[4]));
      if (load && !store)
        outdata <= address == DATA_ADDR ? (empty ? 8'h00 : mem[rp]) :
                   address == STAT_ADDR ? status : 8'h00;
    end
endmodule

// File: tb/tb_link_rx.sv
// tb_link_rx: randomized serial frames and CPU accesses checked against a queue-based model of link_rx
module tb_link_rx;
  localparam int CPB = 16, DEPTH = 4;
  localparam logic [15:0] DA = 16'hff08, SA = 16'hff09;
  localparam int POPC = 3 + CPB / 2 + 9 * CPB - 1;
  localparam int RSTC = 5 * CPB + CPB / 2;
  logic clock4 = 0, reset = 1, load = 0, store = 0, UART_RX = 1, irq;
  logic [15:0] address = 0;
  logic [7:0] indata = 0, outdata;
  int checks = 0, errors = 0, irq_cnt = 0, exp_irq = 0;
  logic [7:0] q [$];
  logic ovf = 0, ferr = 0;
  logic [7:0] last_out = 0;
  link_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock4(clock4), .reset(reset), .address(address), .indata(indata), .outdata(outdata),
    .load(load), .store(store), .UART_RX(UART_RX), .irq(irq)
  );
  always #5 clock4 = ~clock4;
  always @(posedge clock4) if (irq) irq_cnt <= irq_cnt + 1;
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish within 5 ms");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock4);
    #1;
  endtask
  function automatic logic [7:0] stat_model();
    return {q.size() != 0, q.size() == DEPTH, ovf, ferr, 1'b0, 3'(q.size())};
  endfunction
  task automatic cpu(input logic ld, input logic st, input logic [15:0] a, input logic [7:0] d);
    load = ld; store = st; address = a; indata = d;
    tick();
    load = 0; store = 0;
  endtask
  task automatic read_stat();
    last_out = stat_model();
    cpu(1, 0, SA, 8'h00);
    check("status", outdata, last_out);
  endtask
  task automatic read_data();
    last_out = q.size() != 0 ? q.pop_front() : 8'h00;
    cpu(1, 0, DA, 8'h00);
    check("data", outdata, last_out);
  endtask
  task automatic store_stat(input logic [7:0] d);
    cpu(0, 1, SA, d);
    if (d[5]) ovf = 0;
    if (d[4]) ferr = 0;
  endtask
  task automatic other_load();
    logic [15:0] a;
    a = 16'($urandom);
    if (a == DA || a == SA) a = 16'h0000;
    cpu(1, 0, a, 8'h00);
    last_out = 8'h00;
    check("other_addr", outdata, 8'h00);
  endtask
  task automatic both_data();
    cpu(1, 1, DA, 8'($urandom));
    check("store_priority", outdata, last_out);
  endtask
  task automatic glitch();
    UART_RX = 0;
    repeat (CPB / 4) tick();
    UART_RX = 1;
    repeat (2 * CPB) tick();
    check("glitch_irq", irq_cnt, exp_irq);
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input bit pop_mid, input bit rst_mid);
    logic [9:0] fr;
    logic [7:0] pexp;
    fr = {stop, b, 1'b0};
    pexp = 8'h00;
    if (pop_mid) begin
      pexp = q.pop_front();
      last_out = pexp;
    end
    for (int c = 0; c < 10 * CPB; c++) begin
      UART_RX = (rst_mid && c >= RSTC) ? 1'b1 : fr[c/CPB];
      load    = pop_mid && c == POPC;
      address = DA;
      reset   = rst_mid && (c == RSTC || c == RSTC + 1);
      tick();
    end
    load = 0; reset = 0; UART_RX = 1;
    repeat (4 + $urandom_range(0, 6)) tick();
    if (rst_mid) begin
      q.delete();
      ovf = 0; ferr = 0; last_out = 8'h00;
      check("reset_outdata", outdata, 8'h00);
    end else begin
      if (pop_mid) check("coincident_pop", outdata, pexp);
      if (!stop) ferr = 1;
      else if (q.size() < DEPTH) begin
        q.push_back(b);
        exp_irq++;
      end else ovf = 1;
    end
    check("irq_count", irq_cnt, exp_irq);
  endtask
  initial begin
    repeat (3) tick();
    check("reset_outdata", outdata, 8'h00);
    check("reset_irq", irq, 1'b0);
    reset = 0;
    repeat (3) tick();
    read_stat();
    send(8'hA5, 1, 0, 0);
    read_stat();
    check("a5_status", outdata, 8'h81);
    read_data();
    check("a5_data", outdata, 8'hA5);
    read_stat();
    glitch();
    read_stat();
    for (int i = 1; i <= 5; i++) send(8'(i), 1, 0, 0);
    read_stat();
    check("five_status", outdata, 8'hE4);
    repeat (4) read_data();
    store_stat(8'h20);
    read_stat();
    send(8'h3C, 0, 0, 0);
    read_stat();
    send(8'h77, 1, 0, 0);
    read_data();
    store_stat(8'h10);
    read_stat();
    for (int i = 0; i < DEPTH; i++) send(8'($urandom), 1, 0, 0);
    send(8'hC3, 1, 1, 0);
    read_stat();
    check("coincident_status", outdata, 8'hC4);
    both_data();
    read_stat();
    repeat (DEPTH) read_data();
    send(8'h11, 1, 0, 0);
    send(8'h99, 1, 0, 1);
    read_stat();
    send(8'h5A, 1, 0, 0);
    read_data();
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: send(8'($urandom), $urandom_range(0, 7) != 0, 0, 0);
        3: read_data();
        4: read_stat();
        5: store_stat(8'($urandom));
        6: other_load();
        default: if ($urandom_range(0, 1) != 0) glitch(); else both_data();
      endcase
    end
    read_stat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
